// File: rtl/slave_reg_arbiter_pkg.sv
// ============================================================================
// Module      : slave_reg_arbiter_pkg
// Description : Shared encodings for the I2C register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slave_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } i2c_state_t;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_I2C  = 1'b1
  } grant_t;

  localparam logic [7:0] ZERO8       = 8'h00;
  localparam logic [7:0] DEF_CHIP_ID = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/slave_reg_arbiter_rise_detect.sv
// ============================================================================
// Module      : slave_reg_arbiter_rise_detect
// Description : Rising-edge detector on a level input, one-flop history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_reg_arbiter_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b0;
    else        r_last <= i_sig;
  end

  assign o_rise = i_sig & ~r_last;

endmodule

`default_nettype wire

// File: rtl/slave_reg_arbiter.sv
// ============================================================================
// Module      : slave_reg_arbiter
// Description : I2C slave pointer/data sequencer sharing a register bank
//               with a local host port through a fair one-access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_reg_arbiter
  import slave_reg_arbiter_pkg::*;
#(
  parameter int         REG_COUNT = 8,
  parameter logic [7:0] CHIP_ID   = DEF_CHIP_ID,
  localparam int        AW        = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    datareceive,
  input  logic          received,
  output logic [7:0]    datasend,
  input  logic          sended,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_ack,
  output logic          ptr_err
);

  logic w_rx_ev;
  logic w_tx_ev;

  slave_reg_arbiter_rise_detect u_rx_rise (
    .clk   (clk),
    .rst_n (reset),
    .i_sig (received),
    .o_rise(w_rx_ev)
  );

  slave_reg_arbiter_rise_detect u_tx_rise (
    .clk   (clk),
    .rst_n (reset),
    .i_sig (sended),
    .o_rise(w_tx_ev)
  );

  i2c_state_t    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_ptr_err;
  logic          r_pend;
  logic          r_pend_we;
  logic [AW-1:0] r_pend_idx;
  logic [7:0]    r_pend_data;
  grant_t        r_last_grant;
  logic [7:0]    r_bank [REG_COUNT];
  logic [7:0]    r_datasend;
  logic [7:0]    r_host_rdata;
  logic          r_host_ack;

  logic [AW-1:0] w_ptr_inc;
  logic          w_pend_live;
  logic          w_host_live;
  logic          w_contend;
  logic          w_gnt_i2c;
  logic          w_gnt_host;
  logic [7:0]    w_i2c_rdata;
  logic [7:0]    w_host_rdata;

  assign w_ptr_inc = r_ptr + AW'(1);

  // A stop kills a queued fetch in the same cycle; a queued write survives it.
  assign w_pend_live = r_pend & ~(stop & ~r_pend_we);
  assign w_host_live = host_req & ~r_host_ack;
  assign w_contend   = w_pend_live & w_host_live;
  assign w_gnt_i2c   = w_pend_live & (~w_host_live | (r_last_grant == GNT_HOST));
  assign w_gnt_host  = w_host_live & (~w_pend_live | (r_last_grant == GNT_I2C));

  assign w_i2c_rdata  = (r_pend_idx == '0) ? CHIP_ID : r_bank[r_pend_idx];
  assign w_host_rdata = (host_addr  == '0) ? CHIP_ID : r_bank[host_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_ptr_err   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_we   <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_data <= ZERO8;
    end else begin
      if (w_gnt_i2c || (stop && !r_pend_we)) r_pend <= 1'b0;

      // Later queue assignments override the clear above.
      if (start) begin
        r_state   <= ST_PTR;
        r_ptr_err <= 1'b0;
      end else if (stop) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_PTR: begin
            if (w_rx_ev) begin
              r_ptr      <= datareceive[AW-1:0];
              r_ptr_err  <= (datareceive >= 8'(REG_COUNT));
              r_pend     <= 1'b1;
              r_pend_we  <= 1'b0;
              r_pend_idx <= datareceive[AW-1:0];
              r_state    <= ST_WR;
            end else if (w_tx_ev) begin
              r_pend     <= 1'b1;
              r_pend_we  <= 1'b0;
              r_pend_idx <= r_ptr;
              r_state    <= ST_RD;
            end
          end
          ST_WR, ST_RD: begin
            if (w_rx_ev && (r_state == ST_WR)) begin
              if (!r_ptr_err) begin
                r_pend      <= 1'b1;
                r_pend_we   <= 1'b1;
                r_pend_idx  <= r_ptr;
                r_pend_data <= datareceive;
              end
              r_ptr <= w_ptr_inc;
            end else if (w_tx_ev) begin
              r_ptr      <= w_ptr_inc;
              r_pend     <= 1'b1;
              r_pend_we  <= 1'b0;
              r_pend_idx <= w_ptr_inc;
              r_state    <= ST_RD;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_datasend   <= ZERO8;
      r_host_rdata <= ZERO8;
      r_host_ack   <= 1'b0;
      r_last_grant <= GNT_HOST;
      for (int i = 0; i < REG_COUNT; i++) r_bank[i] <= ZERO8;
    end else begin
      r_host_ack <= w_gnt_host;
      if (w_contend) r_last_grant <= w_gnt_host ? GNT_HOST : GNT_I2C;

      if (w_gnt_i2c) begin
        if (r_pend_we) begin
          if (r_pend_idx != '0) r_bank[r_pend_idx] <= r_pend_data;
        end else begin
          r_datasend <= w_i2c_rdata;
        end
      end

      if (w_gnt_host) begin
        if (host_we) begin
          if (host_addr != '0) r_bank[host_addr] <= host_wdata;
        end else begin
          r_host_rdata <= w_host_rdata;
        end
      end
    end
  end

  assign datasend   = r_datasend;
  assign host_rdata = r_host_rdata;
  assign host_ack   = r_host_ack;
  assign ptr_err    = r_ptr_err;

endmodule

`default_nettype wire

// File: tb/tb_slave_reg_arbiter.sv
// ============================================================================
// Module      : tb_slave_reg_arbiter
// Description : Directed plus randomized bench against a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_reg_arbiter;

  localparam int         RC  = 8;
  localparam int         AW  = 3;
  localparam logic [7:0] CID = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [7:0]    datareceive = 8'h00;
  logic          received = 1'b0;
  logic [7:0]    datasend;
  logic          sended = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'h00;
  logic [7:0]    host_rdata;
  logic          host_ack;
  logic          ptr_err;

  int n_asserts = 0;
  int n_fail    = 0;

  // Register-map model: bank contents, pointer, error flag, transaction phase
  // (0 idle, 1 awaiting pointer, 2 writing, 3 reading), last contention winner.
  logic [7:0] m_bank [RC];
  int         m_ptr;
  bit         m_err;
  int         m_phase;
  bit         m_last_host;

  always #5 clk = ~clk;

  slave_reg_arbiter #(.REG_COUNT(RC), .CHIP_ID(CID)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .datareceive(datareceive),
    .received   (received),
    .datasend   (datasend),
    .sended     (sended),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .ptr_err    (ptr_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int idx);
    return (idx == 0) ? CID : m_bank[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RC; i++) m_bank[i] = 8'h00;
    m_ptr = 0; m_err = 1'b0; m_phase = 0; m_last_host = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    m_err = 1'b0; m_phase = 1;
    check("start_clears_err", {7'd0, ptr_err}, 8'd0);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
    m_phase = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    datareceive = b; received = 1'b1;
    repeat (4) @(negedge clk);
    case (m_phase)
      1: begin
        m_ptr = int'(b) % RC; m_err = (int'(b) >= RC); m_phase = 2;
        check("ptr_fetch", datasend, m_read(m_ptr));
      end
      2: begin
        if (!m_err && m_ptr != 0) m_bank[m_ptr] = b;
        m_ptr = (m_ptr + 1) % RC;
      end
      default: ;
    endcase
    check("ptr_err", {7'd0, ptr_err}, {7'd0, m_err});
    received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_edge();
    sended = 1'b1;
    repeat (4) @(negedge clk);
    if (m_phase != 0) begin
      if (m_phase != 1) m_ptr = (m_ptr + 1) % RC;
      m_phase = 3;
      check("rd_data", datasend, m_read(m_ptr));
    end
    sended = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_access(input bit we, input int addr, input logic [7:0] wd);
    int lat;
    int acks;
    logic [7:0] rd;
    lat = 0; acks = 0; rd = 8'h00;
    host_req = 1'b1; host_we = we; host_addr = addr[AW-1:0]; host_wdata = wd;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (host_ack) begin
        acks++;
        if (lat == 0) begin lat = c; rd = host_rdata; end
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    check("host_latency", 8'(lat), 8'd1);
    check("host_ack_once", 8'(acks), 8'd1);
    if (we) begin
      if (addr != 0) m_bank[addr] = wd;
    end else begin
      check("host_rdata", rd, m_read(addr));
    end
  endtask

  // I2C write to reg 2 queued in the same cycle the host asks to write reg 2.
  task automatic contend(input logic [7:0] d_i2c, input logic [7:0] d_host);
    int lat;
    int acks;
    int exp_lat;
    lat = 0; acks = 0;
    pulse_start();
    send_byte(8'h02);
    datareceive = d_i2c; received = 1'b1;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd2; host_wdata = d_host;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (host_ack) begin
        acks++;
        if (lat == 0) lat = c;
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    exp_lat = m_last_host ? 2 : 1;
    m_bank[2] = m_last_host ? d_host : d_i2c;
    m_last_host = ~m_last_host;
    m_ptr = 3;
    check("contend_latency", 8'(lat), 8'(exp_lat));
    check("contend_ack_once", 8'(acks), 8'd1);
    received = 1'b0;
    repeat (2) @(negedge clk);
    pulse_stop();
    host_access(1'b0, 2, 8'h00);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_datasend", datasend, 8'h00);
    check("rst_host_ack", {7'd0, host_ack}, 8'd0);
    check("rst_ptr_err", {7'd0, ptr_err}, 8'd0);
    check("rst_host_rdata", host_rdata, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Read with no pointer byte starts at ptr 0 -> chip ID.
    pulse_start(); send_edge(); pulse_stop();
    host_access(1'b0, 0, 8'h00);

    pulse_start(); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); pulse_stop();
    host_access(1'b0, 3, 8'h00);
    host_access(1'b0, 4, 8'h00);

    host_access(1'b1, 1, 8'hC1);
    host_access(1'b1, 2, 8'hC2);
    host_access(1'b1, 7, 8'hC7);
    pulse_start(); send_byte(8'h07); send_edge(); send_edge(); send_edge(); pulse_stop();

    pulse_start(); send_byte(8'h0F); send_byte(8'h55); pulse_stop();
    for (int i = 0; i < RC; i++) host_access(1'b0, i, 8'h00);
    pulse_start(); pulse_stop();

    contend(8'h3A, 8'h4B);
    contend(8'h5C, 8'h6D);

    // stop coincident with a byte: byte dropped, later bytes ignored until start.
    pulse_start(); send_byte(8'h05);
    datareceive = 8'h99; received = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    received = 1'b0; m_phase = 0;
    repeat (2) @(negedge clk);
    send_byte(8'h66);
    host_access(1'b0, 5, 8'h00);
    host_access(1'b0, 6, 8'h00);
    pulse_start(); send_edge(); pulse_stop();

    // Asynchronous reset in the middle of a write transaction.
    host_access(1'b1, 1, 8'h5A);
    pulse_start(); send_byte(8'h01); send_byte(8'h3C);
    datareceive = 8'h77; received = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_datasend", datasend, 8'h00);
    check("async_rst_ptr_err", {7'd0, ptr_err}, 8'd0);
    check("async_rst_host_ack", {7'd0, host_ack}, 8'd0);
    m_reset();
    @(negedge clk);
    received = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(); send_byte(8'h06); send_byte(8'h42); pulse_stop();
    host_access(1'b0, 6, 8'h00);
    host_access(1'b0, 1, 8'h00);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0: begin
          pulse_start();
          send_byte(8'($urandom_range(15)));
          repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
          pulse_stop();
        end
        1: begin
          pulse_start();
          if ($urandom_range(1) == 1) send_byte(8'($urandom_range(15)));
          repeat ($urandom_range(1, 4)) send_edge();
          pulse_stop();
        end
        2: host_access(1'b1, int'($urandom_range(RC - 1)), 8'($urandom));
        default: host_access(1'b0, int'($urandom_range(RC - 1)), 8'h00);
      endcase
    end
    for (int i = 0; i < RC; i++) host_access(1'b0, i, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slave_reg_arbiter.md
# slave_reg_arbiter

- Sequences the I2C slave byte engine against a small register bank and shares that bank with a local host port.
- Protocol: the first byte after START sets a register pointer. Further received bytes are written at the pointer; sent bytes are read from it, with auto-increment.
- Sits between the slave byte engine (datareceive/received, datasend/sended) and on-chip logic.
- Replaces fixed command decoding with a generic addressable register map.

## Interface
- REG_COUNT, 8: register count, power of two, 2..16; AW = log2(REG_COUNT).
- CHIP_ID, 8'hA5: read-only contents of register 0.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  one-cycle pulse from the byte engine: START addressed to this slave.
- stop  in  1  one-cycle pulse from the byte engine: STOP or repeated START.
- datareceive  in  8  received byte; stable while received is high.
- received  in  1  level; a rising edge means a new byte is on datareceive.
- datasend  out  8  byte for the engine to transmit next.
- sended  in  1  level; a rising edge means datasend was consumed.
- host_req  in  1  host access request; held high until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  AW  host register index.
- host_wdata  in  8  host write data.
- host_rdata  out  8  host read data; valid in the host_ack cycle.
- host_ack  out  1  one-cycle completion pulse.
- ptr_err  out  1  sticky flag: last pointer byte was out of range; cleared at next start.

## Operation
- Bank: REG_COUNT x 8 flops. Reg 0 always reads CHIP_ID; writes to reg 0 are dropped silently from either side.
- Edge detect: registered copies last_received and last_sended. An event occurs when the signal is high and its last copy is low.
- I2C FSM states: IDLE, PTR, WR, RD.
  - IDLE: start -> PTR.
  - PTR, received event: ptr <= byte[AW-1:0]; queue a fetch of reg[ptr] into datasend; go to WR.
    - If byte >= REG_COUNT, ptr_err is set; any pointer value accepted, reg 0 included, still leads to WR.
  - PTR, sended event: read with no pointer. Continue from the retained ptr (initially 0): queue a fetch, go to RD.
  - WR, received event: queue write of byte to reg[ptr]; ptr <= ptr+1 mod REG_COUNT.
    - If ptr_err is set, the write is suppressed but ptr still increments.
  - WR or RD, sended event: ptr <= ptr+1 mod REG_COUNT; queue a fetch of the new ptr; go to RD.
  - Any state, stop -> IDLE. ptr is retained across transactions.
- Each I2C op sets an i2c_pend flag holding the op (write/fetch) and its target index. The flag clears when the op is granted.
- Arbitration, one bank access per cycle:
  - Only i2c_pend, or only host_req (with host_ack low): that side is granted.
  - Both: the side not granted last wins; a last_grant register toggles on contention only.
  - An I2C op therefore waits at most one cycle; a host access waits at most one cycle per I2C op.
- Grants:
  - Fetch grant: datasend <= bank[index].
  - Host grant: host_ack pulses. Reads set host_rdata <= bank[host_addr]; writes set bank[host_addr] <= host_wdata.
- Simultaneous events in one cycle:
  - stop with received/sended: stop wins, the byte event is discarded.
  - start with stop: start wins (repeated START), go to PTR.
  - stop while i2c_pend holds a write: the write still commits; a pending fetch is dropped.
  - Same-register I2C and host writes: serialized by arbitration; the last grant wins.

## Timing
- Reset values: datasend=8'h00, host_rdata=8'h00, host_ack=0, ptr_err=0, ptr=0, FSM=IDLE, bank=0 (reg 0 = CHIP_ID), last_* = 0, last_grant = host.
- I2C event to op queued: 1 cycle (edge detection). Queued to granted: 0 cycles uncontended, 1 cycle contended.
- datasend updated at most 3 cycles after the sended rising edge. The engine needs >= 3 clk before sampling the next byte; guaranteed since SCL << clk.
- host_req to host_ack: 1 cycle uncontended, 2 cycles worst case. The host deasserts host_req in the cycle after host_ack; a still-high host_req then starts a new access.
- Reset asserted mid-transaction: all flops clear asynchronously; the pending op is lost.

## Structure
- Shared package/include: FSM state encodings (IDLE/PTR/WR/RD), ZERO8, default CHIP_ID, grant encodings.
- One sub-module: rise_detect (registered rising-edge detector, async active-low reset), instantiated for received and sended.
- The bank, arbiter and FSM stay in this module.

## Test plan
- Reset: with reset low, datasend=00, host_ack=0, ptr_err=0. Fetch of reg 0 returns A5.
- start, bytes 03,11,22, stop: reg3=11, reg4=22. Host reads of reg 3 and reg 4 return 11 and 22.
- start, byte 07, then three sended edges (REG_COUNT=8):
  - datasend = reg7 after the pointer byte, then reg0=A5, reg1, reg2 on successive edges (wrap).
- start, byte 0F (REG_COUNT=8): ptr_err=1; following byte 55 writes no register. Next start clears ptr_err.
- host_req write to reg 2 in the same cycle the I2C write is queued:
  - alternate grants, both complete within 2 cycles, host_ack seen exactly once.
  - repeat with last_grant flipped.
- stop in the same cycle as a received edge: byte dropped, FSM=IDLE, no register changes.
- Async reset mid-WR: outputs clear within the same cycle; a following transaction behaves normally.
